// File: rtl/trace_counter_bank.sv
// rtl/trace_counter_bank.sv - multi-channel event counter bank with atomic snapshot readout
module trace_counter_bank #(
    parameter int width_p         = 16,
    parameter int channels_p      = 4,
    parameter int init_val_p      = 0,
    parameter int saturate_p      = 0,
    parameter int clear_on_snap_p = 0,
    localparam int ch_w_lp        = (channels_p > 1) ? $clog2(channels_p) : 1
) (
    input  logic                            clk,
    input  logic                            reset_n_i,
    input  logic [channels_p-1:0]           en_i,
    input  logic [channels_p-1:0]           clear_i,
    input  logic                            snap_i,
    output logic [channels_p*width_p-1:0]   ctr_r_o,
    output logic [channels_p-1:0]           ovf_r_o,
    output logic                            busy_o,
    output logic                            v_o,
    input  logic                            ready_i,
    output logic [width_p-1:0]              data_o,
    output logic [ch_w_lp-1:0]              ch_o,
    output logic                            ovf_o
);

    typedef enum logic {IDLE, DUMP} state_t;

    localparam logic [width_p-1:0] init_lp = width_p'(init_val_p);
    localparam logic [width_p-1:0] max_lp  = '1;
    localparam logic [ch_w_lp-1:0] last_lp = ch_w_lp'(channels_p - 1);

    state_t               state_q, state_d;
    logic [ch_w_lp-1:0]   idx_q, idx_d;
    logic [width_p-1:0]   ctr_q [channels_p];
    logic [width_p-1:0]   ctr_d [channels_p];
    logic [channels_p-1:0] ovf_q, ovf_d;
    logic [width_p-1:0]   snap_ctr_q [channels_p];
    logic [channels_p-1:0] snap_ovf_q;
    logic                 snap_accept;
    logic                 clear_all;

    // Counter update: clear (including clear-on-snap) beats increment.
    always_comb begin
        snap_accept = (state_q == IDLE) && snap_i;
        clear_all   = snap_accept && (clear_on_snap_p != 0);
        ovf_d       = ovf_q;
        for (int k = 0; k < channels_p; k++) begin
            ctr_d[k] = ctr_q[k];
            if (clear_i[k] || clear_all) begin
                ctr_d[k] = init_lp;
                ovf_d[k] = 1'b0;
            end else if (en_i[k]) begin
                if (ctr_q[k] == max_lp) begin
                    ctr_d[k] = (saturate_p != 0) ? max_lp : '0;
                    ovf_d[k] = 1'b1;
                end else begin
                    ctr_d[k] = ctr_q[k] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            IDLE: begin
                if (snap_i) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                if (ready_i) begin
                    if (idx_q == last_lp) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Snapshot regs take the pre-update values so the capture is atomic.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= '0;
            for (int k = 0; k < channels_p; k++) begin
                ctr_q[k] <= init_lp;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            ctr_q   <= ctr_d;
            if (snap_accept) begin
                snap_ctr_q <= ctr_q;
                snap_ovf_q <= ovf_q;
            end
        end
    end

    for (genvar g = 0; g < channels_p; g++) begin : g_ctr_out
        assign ctr_r_o[g*width_p +: width_p] = ctr_q[g];
    end

    assign ovf_r_o = ovf_q;
    assign busy_o  = (state_q == DUMP);
    assign v_o     = (state_q == DUMP);
    assign ch_o    = idx_q;
    assign data_o  = snap_ctr_q[idx_q];
    assign ovf_o   = snap_ovf_q[idx_q];

endmodule
